// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: generates the fetch PC, issues pipelined in-order
// requests and buffers returned instructions in a DEPTH-entry queue for decode.
module if_fetch_queue #(
    parameter int               WIDTH      = 32,
    parameter int               DEPTH      = 4,
    parameter int               MAX_OUT    = 2,
    parameter logic [WIDTH-1:0] RESET_PC   = 32'hbfc0_0000,
    parameter logic [WIDTH-1:0] EXC_VEC    = 32'hbfc0_0380,
    parameter logic [WIDTH-1:0] REFILL_VEC = 32'hbfc0_0200
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     exc_valid,
    input  logic                     exc_refill,
    input  logic                     redirect_valid,
    input  logic [WIDTH-1:0]         redirect_pc,
    output logic                     mem_req,
    output logic [WIDTH-1:0]         mem_addr,
    input  logic                     mem_addr_ok,
    input  logic                     mem_data_ok,
    input  logic [31:0]              mem_rdata,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [WIDTH-1:0]         deq_pc,
    output logic [31:0]              deq_instr,
    output logic                     deq_adel,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] resp_pc;
    logic [LW-1:0]    out_cnt;
    logic [LW-1:0]    drop_cnt;
    logic [LW-1:0]    count;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             stopped;

    logic [WIDTH-1:0] q_pc    [DEPTH];
    logic [31:0]      q_instr [DEPTH];
    logic [DEPTH-1:0] q_adel;

    logic             flush;
    logic [WIDTH-1:0] flush_pc;
    logic [LW:0]      reserved;
    logic             accept;
    logic             resp;
    logic             resp_keep;
    logic             adel_enq;
    logic             enq;
    logic             deq;
    logic [WIDTH-1:0] enq_pc;
    logic [31:0]      enq_instr;
    logic             enq_adel;

    assign flush = exc_valid | redirect_valid;

    always_comb begin
        flush_pc = redirect_pc;
        if (exc_valid) begin
            flush_pc = exc_refill ? REFILL_VEC : EXC_VEC;
        end
    end

    // Slots already promised to kept in-flight responses count as occupied,
    // so a kept response always finds room in the queue.
    assign reserved = {1'b0, count} + {1'b0, out_cnt} - {1'b0, drop_cnt};

    assign mem_req = ~rst & ~flush & ~stopped
                   & (fetch_pc[1:0] == 2'b00)
                   & (out_cnt < LW'(MAX_OUT))
                   & (reserved < (LW+1)'(DEPTH));
    assign mem_addr = fetch_pc;
    assign accept   = mem_req & mem_addr_ok;

    // A response with nothing outstanding (e.g. a pre-reset request) is ignored.
    assign resp      = mem_data_ok & (out_cnt != '0);
    assign resp_keep = resp & (drop_cnt == '0);

    // Address-error entry goes in only after every kept response has landed,
    // which keeps queue order equal to program order.
    assign adel_enq = ~stopped & (fetch_pc[1:0] != 2'b00)
                    & (out_cnt == drop_cnt) & (count < LW'(DEPTH));

    assign enq       = ~flush & (resp_keep | adel_enq);
    assign deq       = ~flush & deq_valid & deq_ready;
    assign enq_pc    = resp_keep ? resp_pc : fetch_pc;
    assign enq_instr = resp_keep ? mem_rdata : 32'h0;
    assign enq_adel  = ~resp_keep;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
            stopped  <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            out_cnt <= out_cnt + LW'(accept) - LW'(resp);
            if (flush) begin
                fetch_pc <= flush_pc;
                resp_pc  <= flush_pc;
                drop_cnt <= out_cnt - LW'(resp);
                stopped  <= 1'b0;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + WIDTH'(4);
                end
                if (resp && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - LW'(1);
                end
                if (resp_keep) begin
                    resp_pc <= resp_pc + WIDTH'(4);
                end
                if (adel_enq) begin
                    stopped <= 1'b1;
                end
                if (enq) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (deq) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + LW'(enq) - LW'(deq);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_pc[wr_ptr]    <= enq_pc;
            q_instr[wr_ptr] <= enq_instr;
            q_adel[wr_ptr]  <= enq_adel;
        end
    end

    assign deq_valid = (count != '0);
    assign deq_pc    = q_pc[rd_ptr];
    assign deq_instr = q_instr[rd_ptr];
    assign deq_adel  = q_adel[rd_ptr];
    assign level     = count;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomised bench for if_fetch_queue: a latency-configurable memory model and a
// program-order stream scoreboard checked by an independent monitor.
module tb_if_fetch_queue;

    localparam int          WIDTH      = 32;
    localparam int          DEPTH      = 4;
    localparam int          MAX_OUT    = 2;
    localparam logic [31:0] RESET_PC   = 32'hbfc0_0000;
    localparam logic [31:0] EXC_VEC    = 32'hbfc0_0380;
    localparam logic [31:0] REFILL_VEC = 32'hbfc0_0200;
    localparam int          WINDOW     = 400;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   exc_valid;
    logic                   exc_refill;
    logic                   redirect_valid;
    logic [WIDTH-1:0]       redirect_pc;
    logic                   mem_req;
    logic [WIDTH-1:0]       mem_addr;
    logic                   mem_addr_ok;
    logic                   mem_data_ok;
    logic [31:0]            mem_rdata;
    logic                   deq_valid;
    logic                   deq_ready;
    logic [WIDTH-1:0]       deq_pc;
    logic [31:0]            deq_instr;
    logic                   deq_adel;
    logic [$clog2(DEPTH):0] level;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } pend_t;

    exp_t        exp_q[$];
    pend_t       pend[$];
    logic [31:0] acc_log[$];
    exp_t        mon_e;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cnt  = 0;
    int deq_cnt  = 0;
    int mem_lat  = 1;
    int mem_jit  = 0;
    bit mem_rand_ok = 1'b0;

    if_fetch_queue #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT),
        .RESET_PC(RESET_PC), .EXC_VEC(EXC_VEC), .REFILL_VEC(REFILL_VEC)
    ) dut (
        .clk(clk), .rst(rst),
        .exc_valid(exc_valid), .exc_refill(exc_refill),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc),
        .deq_instr(deq_instr), .deq_adel(deq_adel), .level(level)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected decode stream after a flush: sequential words from the target,
    // or a single address-error entry when the target is misaligned.
    task automatic set_stream(input logic [31:0] tgt);
        logic [31:0] p;
        exp_q.delete();
        if (tgt[1:0] != 2'b00) begin
            exp_q.push_back('{tgt, 32'h0, 1'b1});
        end else begin
            for (int i = 0; i < WINDOW; i++) begin
                p = tgt + 32'(4 * i);
                exp_q.push_back('{p, instr_of(p), 1'b0});
            end
        end
    endtask

    // Called and returns at posedge+#1.
    task automatic do_flush(input logic ex, input logic refill, input logic rd,
                            input logic [31:0] tgt);
        exc_valid      = ex;
        exc_refill     = refill;
        redirect_valid = rd;
        redirect_pc    = tgt;
        if (ex) set_stream(refill ? REFILL_VEC : EXC_VEC);
        else    set_stream(tgt);
        acc_log.delete();
        @(negedge clk);
        check("flush_mem_req", mem_req, 0);
        @(posedge clk); #1;
        exc_valid      = 1'b0;
        exc_refill     = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic wait_consumed(input int n, input string name);
        int k;
        k = 0;
        while (exp_q.size() > WINDOW - n && k < 80) begin
            @(posedge clk); #1;
            k++;
        end
        if (exp_q.size() > WINDOW - n) begin
            checks++; failures++;
            $display("FAIL %s timeout actual_remaining=%0d required<=%0d", name, exp_q.size(), WINDOW - n);
        end
    endtask

    // In-order memory: accepts on mem_req & mem_addr_ok, answers after a latency.
    initial begin
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            mem_addr_ok = mem_rand_ok ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                mem_data_ok = 1'b1;
                mem_rdata   = pend[0].data;
            end else begin
                mem_data_ok = 1'b0;
                mem_rdata   = $urandom;
            end
            @(negedge clk);
            if (rst) begin
                pend.delete();
            end else begin
                if (mem_data_ok) void'(pend.pop_front());
                if (mem_req && mem_addr_ok) begin
                    pend.push_back('{instr_of(mem_addr), cyc + mem_lat + int'($urandom_range(0, mem_jit))});
                    acc_cnt++;
                    acc_log.push_back(mem_addr);
                end
            end
        end
    end

    // Monitor: every accepted dequeue outside a flush cycle pops the scoreboard.
    initial forever begin
        @(negedge clk);
        if (!rst && deq_valid && deq_ready && !exc_valid && !redirect_valid) begin
            deq_cnt++;
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL deq_unexpected actual_pc=%0h required=no_entry", deq_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("deq_entry", {deq_pc, deq_instr, deq_adel}, {mon_e.pc, mon_e.instr, mon_e.adel});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int a0;
        int k;
        bit ok;
        int d0;
        logic [31:0] tgt;
        int r;

        rst = 1'b1; deq_ready = 1'b0;
        exc_valid = 1'b0; exc_refill = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        set_stream(RESET_PC);
        repeat (3) begin
            @(negedge clk);
            check("rst_mem_req", mem_req, 0);
            check("rst_deq_valid", deq_valid, 0);
            check("rst_level", level, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        deq_ready = 1'b1;
        @(negedge clk);
        check("post_rst_addr", mem_addr, RESET_PC);

        // Sequential fetch with a 1-cycle memory
        repeat (2) @(posedge clk);
        a0 = acc_cnt;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (level > 1) ok = 1'b0;
            @(posedge clk);
        end
        check("throughput", acc_cnt - a0, 20);
        check("level_le1", ok, 1);
        for (int i = 0; i < 4; i++) check("seq_addr", acc_log[i], RESET_PC + 32'(4 * i));
        #1;

        // Decode stalled: queue fills and fetch stops
        deq_ready = 1'b0;
        do_flush(0, 0, 1, 32'h8000_0000);
        a0 = acc_cnt;
        repeat (12) @(posedge clk);
        check("stall_accepts", acc_cnt - a0, DEPTH);
        @(negedge clk);
        check("stall_level", level, DEPTH);
        check("stall_mem_req", mem_req, 0);
        @(posedge clk); #1;
        deq_ready = 1'b1;
        a0 = acc_cnt;
        k = 0;
        while (acc_cnt == a0 && k < 6) begin @(posedge clk); #1; k++; end
        check("resume_fetch", acc_cnt > a0, 1);
        wait_consumed(8, "resume_drain");

        // Redirect with two requests in flight
        mem_lat = 3;
        do_flush(0, 0, 1, RESET_PC);
        k = 0;
        while (!(acc_log.size() >= 4 && pend.size() >= 2) && k < 30) begin
            @(posedge clk); #1; k++;
        end
        if (acc_log.size() >= 4) begin
            check("inflight_a2", acc_log[2], 32'hbfc0_0008);
            check("inflight_a3", acc_log[3], 32'hbfc0_000c);
        end else begin
            checks++; failures++;
            $display("FAIL inflight_setup actual=%0d required=4", acc_log.size());
        end
        do_flush(0, 0, 1, 32'h8000_1000);
        wait_consumed(3, "redirect_drop");
        mem_lat = 1;

        // Exception beats a simultaneous redirect
        do_flush(1, 1, 1, 32'h8000_2000);
        @(negedge clk);
        check("exc_refill_addr", mem_addr, REFILL_VEC);
        @(posedge clk); #1;
        wait_consumed(2, "exc_refill_drain");
        do_flush(1, 0, 1, 32'h8000_2000);
        @(negedge clk);
        check("exc_gen_addr", mem_addr, EXC_VEC);
        @(posedge clk); #1;
        wait_consumed(2, "exc_gen_drain");

        // Misaligned redirect: address-error entry, then idle
        do_flush(0, 0, 1, 32'h8000_0002);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req) ok = 1'b0;
        end
        check("adel_no_req", ok, 1);
        @(posedge clk); #1;
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin @(posedge clk); #1; k++; end
        check("adel_consumed", exp_q.size(), 0);
        d0 = deq_cnt;
        repeat (10) @(posedge clk);
        #1;
        check("adel_idle", deq_cnt - d0, 0);

        // PC wrap-around
        do_flush(0, 0, 1, 32'hffff_fffc);
        k = 0;
        while (acc_log.size() < 2 && k < 20) begin @(posedge clk); #1; k++; end
        if (acc_log.size() >= 2) begin
            check("wrap_a0", acc_log[0], 32'hffff_fffc);
            check("wrap_a1", acc_log[1], 32'h0000_0000);
        end else begin
            checks++; failures++;
            $display("FAIL wrap_setup actual=%0d required=2", acc_log.size());
        end
        wait_consumed(3, "wrap_drain");

        // Randomised traffic
        mem_rand_ok = 1'b1;
        mem_lat = 1;
        mem_jit = 3;
        d0 = deq_cnt;
        for (int i = 0; i < 2000; i++) begin
            deq_ready = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 99);
            if (r < 3) begin
                tgt = $urandom;
                tgt[1:0] = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b00;
                do_flush(0, 0, 1, tgt);
            end else if (r < 4) begin
                do_flush(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            end else begin
                @(posedge clk); #1;
            end
        end
        check("random_activity", (deq_cnt - d0) > 200, 1);
        mem_rand_ok = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
